// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port simulation RAM between the instruction-fetch master
// and the data load/store master. One master is granted at a time; byte
// addresses become word indices, WAIT_CYCLES busy cycles are inserted per
// access and read data is registered per port.
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   i_address/i_read                 instruction master request
//   i_waitrequest/i_readdata/i_error instruction master response
//   d_address/d_read/d_write/d_writedata  data master request
//   d_waitrequest/d_readdata/d_error      data master response
//   mem_address/mem_read/mem_write/mem_writedata/mem_readdata  RAM side
//
// Build option: ARB_ROUND_ROBIN_EN selects round-robin on ties; without it
// the data master always wins a tie.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and check the winner's address
// BUSY  | RAM access in progress, cnt counts down the wait states
// DONE  | owner's waitrequest drops for one cycle; error pulses if rejected
module ram_port_arbiter #(
    parameter int ADDR_WIDTH  = 11,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    output logic        i_error,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic        d_error,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]            state;
    logic                  owner;
    logic                  last_grant;
    logic                  rejected;
    logic [3:0]            cnt;
    logic [31:0]           i_rdata_q;
    logic [31:0]           d_rdata_q;

    logic                  i_req;
    logic                  d_req;
    logic                  grant_d;
    logic [31:0]           req_addr;
    logic                  req_ok;
    logic [31:0]           own_addr;
    logic                  own_write;
    logic [ADDR_WIDTH-1:0] own_word;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (ADDR_WIDTH + 2)) == 32'd0);
    endfunction

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the master that was not served last wins.
    assign grant_d = d_req && (!i_req || (last_grant == OWN_I));
`else
    assign grant_d = d_req;
    // last_grant is kept up to date so both builds share one register map.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign req_addr  = grant_d ? d_address : i_address;
    assign req_ok    = addr_ok(req_addr);
    assign own_addr  = (owner == OWN_D) ? d_address : i_address;
    // Read and write together on the data port counts as a write.
    assign own_write = (owner == OWN_D) && d_write;
    assign own_word  = own_addr[ADDR_WIDTH+1:2];

    always_comb begin
        mem_address   = 32'd0;
        mem_writedata = 32'd0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        if (state == S_BUSY) begin
            mem_address = {{(32-ADDR_WIDTH){1'b0}}, own_word};
            if (owner == OWN_D) begin
                mem_writedata = d_writedata;
            end
            mem_read  = !own_write;
            // Only the last busy cycle strobes the write, so a store lands once.
            mem_write = own_write && (cnt == 4'd0);
        end
    end

    assign i_waitrequest = i_req && !((state == S_DONE) && (owner == OWN_I));
    assign d_waitrequest = d_req && !((state == S_DONE) && (owner == OWN_D));
    assign i_error       = (state == S_DONE) && (owner == OWN_I) && rejected;
    assign d_error       = (state == S_DONE) && (owner == OWN_D) && rejected;
    assign i_readdata    = i_rdata_q;
    assign d_readdata    = d_rdata_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            rejected   <= 1'b0;
            cnt        <= 4'd0;
            i_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        owner <= grant_d;
                        cnt   <= 4'(WAIT_CYCLES - 1);
                        if (req_ok) begin
                            rejected <= 1'b0;
                            state    <= S_BUSY;
                        end else begin
                            // Rejected reads return zero; no RAM strobe at all.
                            rejected <= 1'b1;
                            state    <= S_DONE;
                            if (grant_d) begin
                                if (!d_write) begin
                                    d_rdata_q <= 32'd0;
                                end
                            end else begin
                                i_rdata_q <= 32'd0;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd0) begin
                        if (!own_write) begin
                            if (owner == OWN_D) begin
                                d_rdata_q <= mem_readdata;
                            end else begin
                                i_rdata_q <= mem_readdata;
                            end
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    last_grant <= owner;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. The main instance runs with one wait
// state; a second instance with three wait states is used for the reset
// mid-access case. Expected results are queued when an access is issued and
// popped when the arbiter completes it.
module tb_ram_port_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic resetn, resetn3;
    logic preload;

    logic [31:0] i_address, d_address, d_writedata;
    logic        i_read, d_read, d_write;
    logic        i_waitrequest, d_waitrequest, i_error, d_error;
    logic [31:0] i_readdata, d_readdata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write;

    logic [31:0] i3_address, d3_address, d3_writedata;
    logic        i3_read, d3_read, d3_write;
    logic        i3_waitrequest, d3_waitrequest, i3_error, d3_error;
    logic [31:0] i3_readdata, d3_readdata;
    logic [31:0] mem3_address, mem3_writedata, mem3_readdata;
    logic        mem3_read, mem3_write;

    logic [31:0] ram  [0:2047];
    logic [31:0] ram3 [0:2047];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, wr_cnt = 0, wr3_cnt = 0;
    logic [31:0] rd_addr = 32'd0, wr_addr = 32'd0;

    exp_t        sb_q[$];
    logic [7:0]  grant_q[$];

    ram_port_arbiter #(.ADDR_WIDTH(11), .WAIT_CYCLES(1)) dut (
        .clk(clk), .resetn(resetn),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
        .i_readdata(i_readdata), .i_error(i_error),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_waitrequest(d_waitrequest),
        .d_readdata(d_readdata), .d_error(d_error),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    ram_port_arbiter #(.ADDR_WIDTH(11), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .resetn(resetn3),
        .i_address(i3_address), .i_read(i3_read), .i_waitrequest(i3_waitrequest),
        .i_readdata(i3_readdata), .i_error(i3_error),
        .d_address(d3_address), .d_read(d3_read), .d_write(d3_write),
        .d_writedata(d3_writedata), .d_waitrequest(d3_waitrequest),
        .d_readdata(d3_readdata), .d_error(d3_error),
        .mem_address(mem3_address), .mem_read(mem3_read), .mem_write(mem3_write),
        .mem_writedata(mem3_writedata), .mem_readdata(mem3_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_readdata  = ram[mem_address[10:0]];
    assign mem3_readdata = ram3[mem3_address[10:0]];

    always @(posedge clk) begin
        if (preload) begin
            ram[2]  <= 32'h2402000A;
            ram[3]  <= 32'h33333333;
            ram3[8] <= 32'h00000000;
        end else begin
            if (mem_write)  ram[mem_address[10:0]]   <= mem_writedata;
            if (mem3_write) ram3[mem3_address[10:0]] <= mem3_writedata;
        end
    end

    always @(negedge clk) begin
        if (mem_read) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= mem_address;
        end
        if (mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_address;
        end
        if (mem3_write) wr3_cnt <= wr3_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input bit is_d, input logic [31:0] addr, input bit rd,
                             input bit wr, input logic [31:0] wdata,
                             input logic [31:0] exp_data, input bit exp_err,
                             input int exp_cyc, input string tag);
        int   n;
        bit   done;
        exp_t e;
        sb_q.push_back('{data: exp_data, err: exp_err, cyc: exp_cyc});
        @(negedge clk);
        if (is_d) begin
            d_address = addr; d_read = rd; d_write = wr; d_writedata = wdata;
        end else begin
            i_address = addr; i_read = 1'b1;
        end
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (is_d ? !d_waitrequest : !i_waitrequest) done = 1'b1;
        end
        e = sb_q.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, 32'(n + 1), 32'(e.cyc));
        check({tag, "_rdata"}, is_d ? d_readdata : i_readdata, e.data);
        check({tag, "_err"}, 32'(is_d ? d_error : i_error), 32'(e.err));
        @(posedge clk); #1;
        if (is_d) begin
            d_read = 1'b0; d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        check({tag, "_err_pulse"}, 32'(is_d ? d_error : i_error), 32'd0);
    endtask

    initial begin
        int rd0, wr0, w30, gcnt, icnt, n;
        logic [7:0] g;
        resetn = 1'b0; resetn3 = 1'b0; preload = 1'b1;
        i_address = 32'd0; i_read = 1'b1;
        d_address = 32'd0; d_read = 1'b0; d_write = 1'b0; d_writedata = 32'd0;
        i3_address = 32'd0; i3_read = 1'b0;
        d3_address = 32'd0; d3_read = 1'b0; d3_write = 1'b0; d3_writedata = 32'd0;

        // Reset with an instruction request pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_i_rdata", i_readdata, 32'd0);
        check("rst_d_rdata", d_readdata, 32'd0);
        check("rst_i_wait", 32'(i_waitrequest), 32'd1);
        check("rst_errs", {30'd0, i_error, d_error}, 32'd0);
        i_read = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        resetn = 1'b1; resetn3 = 1'b1;

        // Instruction fetch of word 2.
        rd0 = rd_cnt;
        do_access(1'b0, 32'h8, 1'b1, 1'b0, 32'd0, 32'h2402000A, 1'b0, 3, "ifetch");
        check("ifetch_mem_addr", rd_addr, 32'd2);
        check("ifetch_rd_cycles", 32'(rd_cnt - rd0), 32'd1);

        // Store then load.
        wr0 = wr_cnt;
        do_access(1'b1, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 32'd0, 1'b0, 3, "store");
        check("store_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("store_wr_addr", wr_addr, 32'd4);
        check("store_ram", ram[4], 32'hDEADBEEF);
        do_access(1'b1, 32'h10, 1'b1, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, 3, "load");
        check("load_mem_addr", rd_addr, 32'd4);

        // Read and write together behaves as a write; load data is kept.
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_access(1'b1, 32'h14, 1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF, 1'b0, 3, "rdwr");
        check("rdwr_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("rdwr_rd_count", 32'(rd_cnt - rd0), 32'd0);
        check("rdwr_ram", ram[5], 32'h12345678);

        // Misaligned and out-of-range loads are rejected.
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_access(1'b1, 32'h6, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 2, "rej_align");
        do_access(1'b1, 32'h2000, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 2, "rej_range");
        check("rej_rd_count", 32'(rd_cnt - rd0), 32'd0);
        check("rej_wr_count", 32'(wr_cnt - wr0), 32'd0);

        // Contention from a fresh reset with both requests held.
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        i_address = 32'h8; d_address = 32'hC; i_read = 1'b1; d_read = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        grant_q.push_back("D"); grant_q.push_back("I");
        grant_q.push_back("D"); grant_q.push_back("I");
`else
        grant_q.push_back("D"); grant_q.push_back("D");
        grant_q.push_back("D"); grant_q.push_back("D");
`endif
        gcnt = 0; icnt = 0; n = 0;
        while (gcnt < 4 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (!d_waitrequest || !i_waitrequest) begin
                g = grant_q.pop_front();
                check("cont_grant", !d_waitrequest ? 32'h44 : 32'h49, 32'(g));
                if (!d_waitrequest) check("cont_d_rdata", d_readdata, 32'h33333333);
                else begin
                    icnt++;
                    check("cont_i_rdata", i_readdata, 32'h2402000A);
                end
                gcnt++;
            end
        end
        check("cont_grants_seen", 32'(gcnt), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
        check("cont_i_grants", 32'(icnt), 32'd2);
`else
        check("cont_i_grants", 32'(icnt), 32'd0);
        check("cont_i_stalled", 32'(i_waitrequest), 32'd1);
`endif
        @(posedge clk); #1;
        i_read = 1'b0; d_read = 1'b0;

        // Reset during the second busy cycle of a store with three wait states.
        w30 = wr3_cnt;
        @(negedge clk);
        d3_address = 32'h20; d3_writedata = 32'hCAFEF00D; d3_write = 1'b1;
        @(posedge clk); #1;
        check("mid_busy1_wait", 32'(d3_waitrequest), 32'd1);
        @(posedge clk); #1;
        resetn3 = 1'b0;
        @(posedge clk); #1;
        check("mid_mem_write", 32'(mem3_write), 32'd0);
        check("mid_mem_read", 32'(mem3_read), 32'd0);
        check("mid_mem_addr", mem3_address, 32'd0);
        check("mid_err", 32'(d3_error), 32'd0);
        check("mid_wait_idle", 32'(d3_waitrequest), 32'd1);
        d3_write = 1'b0;
        #1;
        check("mid_wait_drop", 32'(d3_waitrequest), 32'd0);
        @(negedge clk); resetn3 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_wr_count", 32'(wr3_cnt - w30), 32'd0);
        check("mid_ram", ram3[8], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
